// File: rtl/mandel_pkg.sv
// Shared constants for the Mandelbrot pixel pipeline: Q4.12 format, escape
// threshold and default 640x480 video timing.
package mandel_pkg;
  localparam int FRAC_BITS = 12;
  localparam int WORD_W    = 16;
  localparam int CNT_W     = 8;

  localparam logic signed [WORD_W-1:0] ESCAPE_THRESH = 16'sh4000;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  function automatic int ctr_width(input int total);
    return (total > 1) ? $clog2(total) : 1;
  endfunction
endpackage

// File: rtl/mandel_pixel_gen_timing.sv
// Video timing: h/v counters advanced by the pixel enable, plus position
// decodes for the current (h,v) that the top registers alongside c.
module video_timing
  import mandel_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic ce_i,
  output logic de_o,
  output logic hs_o,
  output logic vs_o,
  output logic hact_o,
  output logic sof_o,
  output logic sol_o,
  output logic eol_o
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = ctr_width(H_TOTAL);
  localparam int VW = ctr_width(V_TOTAL);

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [31:0]   h32, v32;
  logic          vact;

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (ce_i) begin
      if (h_q == HW'(H_TOTAL - 1)) begin
        h_d = '0;
        v_d = (v_q == VW'(V_TOTAL - 1)) ? '0 : v_q + VW'(1);
      end else begin
        h_d = h_q + HW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  // Compare in 32 bits so porch boundaries never alias in a narrow counter.
  assign h32    = 32'(h_q);
  assign v32    = 32'(v_q);
  assign hact_o = h32 < 32'(H_ACTIVE);
  assign vact   = v32 < 32'(V_ACTIVE);
  assign de_o   = hact_o && vact;
  assign hs_o   = (h32 >= 32'(H_ACTIVE + H_FP)) && (h32 < 32'(H_ACTIVE + H_FP + H_SYNC));
  assign vs_o   = (v32 >= 32'(V_ACTIVE + V_FP)) && (v32 < 32'(V_ACTIVE + V_FP + V_SYNC));
  assign sol_o  = (h_q == '0);
  assign sof_o  = sol_o && (v_q == '0);
  assign eol_o  = (h32 == 32'(H_ACTIVE - 1)) && vact;
endmodule

// File: rtl/mandel_pixel_gen.sv
// Pipeline head: video timing plus per-pixel c = (cx0 + h*step, cy0 - v*step)
// built by accumulation, seeding the iteration chain with z = 0, count = 0.
module mandel_pixel_gen
  import mandel_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_ce,
  input  logic signed [WORD_W-1:0] i_cx0,
  input  logic signed [WORD_W-1:0] i_cy0,
  input  logic signed [WORD_W-1:0] i_step,
  output logic                     o_de,
  output logic                     o_hs,
  output logic                     o_vs,
  output logic signed [WORD_W-1:0] o_x,
  output logic signed [WORD_W-1:0] o_y,
  output logic signed [WORD_W-1:0] o_cx,
  output logic signed [WORD_W-1:0] o_cy,
  output logic [CNT_W-1:0]         o_cnt
);
  logic de, hs, vs, hact, sof, sol, eol;

  video_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk_i  (i_clk),
    .rst_i  (i_rst),
    .ce_i   (i_ce),
    .de_o   (de),
    .hs_o   (hs),
    .vs_o   (vs),
    .hact_o (hact),
    .sof_o  (sof),
    .sol_o  (sol),
    .eol_o  (eol)
  );

  logic signed [WORD_W-1:0] cx0_q, cx0_d, cy0_q, cy0_d, step_q, step_d;
  logic signed [WORD_W-1:0] cxa_q, cxa_d, cya_q, cya_d;
  logic signed [WORD_W-1:0] cx_q, cx_d, cy_q, cy_d;
  logic signed [WORD_W-1:0] cx0_cur, step_cur, cx_cur, cy_cur;
  logic                     de_q, de_d, hs_q, hs_d, vs_q, vs_d;

  always_comb begin
    // The frame-start pixel sees the live inputs; everything else the shadows.
    cx0_cur  = sof ? i_cx0  : cx0_q;
    step_cur = sof ? i_step : step_q;
    cx_cur   = sol ? cx0_cur : cxa_q;
    cy_cur   = sof ? i_cy0  : cya_q;

    cx0_d  = cx0_q;
    cy0_d  = cy0_q;
    step_d = step_q;
    cxa_d  = cxa_q;
    cya_d  = cya_q;
    de_d   = de_q;
    hs_d   = hs_q;
    vs_d   = vs_q;
    cx_d   = cx_q;
    cy_d   = cy_q;

    if (i_ce) begin
      if (sof) begin
        cx0_d  = i_cx0;
        cy0_d  = i_cy0;
        step_d = i_step;
      end
      if (hact) cxa_d = cx_cur + step_cur;
      cya_d = eol ? cy_cur - step_cur : cy_cur;
      de_d  = de;
      hs_d  = hs;
      vs_d  = vs;
      cx_d  = de ? cx_cur : '0;
      cy_d  = de ? cy_cur : '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cx0_q  <= '0;
      cy0_q  <= '0;
      step_q <= '0;
      cxa_q  <= '0;
      cya_q  <= '0;
      de_q   <= 1'b0;
      hs_q   <= 1'b0;
      vs_q   <= 1'b0;
      cx_q   <= '0;
      cy_q   <= '0;
    end else begin
      cx0_q  <= cx0_d;
      cy0_q  <= cy0_d;
      step_q <= step_d;
      cxa_q  <= cxa_d;
      cya_q  <= cya_d;
      de_q   <= de_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      cx_q   <= cx_d;
      cy_q   <= cy_d;
    end
  end

  assign o_de  = de_q;
  assign o_hs  = hs_q;
  assign o_vs  = vs_q;
  assign o_cx  = cx_q;
  assign o_cy  = cy_q;
  assign o_x   = '0;
  assign o_y   = '0;
  assign o_cnt = '0;
endmodule

// File: tb/tb_mandel_pixel_gen.sv
// Randomized self-checking bench for mandel_pixel_gen on a tiny 8x6 raster.
module tb_mandel_pixel_gen;
  localparam int HA = 4, HF = 1, HS = 2, HB = 1;
  localparam int VA = 3, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  logic        i_clk = 1'b0, i_rst = 1'b1, i_ce = 1'b0;
  logic [15:0] i_cx0 = '0, i_cy0 = '0, i_step = '0;
  logic        o_de, o_hs, o_vs;
  logic [15:0] o_x, o_y, o_cx, o_cy;
  logic [7:0]  o_cnt;

  mandel_pixel_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_ce(i_ce),
    .i_cx0(i_cx0), .i_cy0(i_cy0), .i_step(i_step),
    .o_de(o_de), .o_hs(o_hs), .o_vs(o_vs),
    .o_x(o_x), .o_y(o_y), .o_cx(o_cx), .o_cy(o_cy), .o_cnt(o_cnt)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0, failures = 0;

  // Reference model: position index within the frame, frame parameters
  // latched at index 0, and c computed directly by multiplication.
  int          pos;
  logic [15:0] sh_cx, sh_cy, sh_st;
  logic        e_de, e_hs, e_vs;
  logic [15:0] e_cx, e_cy;
  logic [74:0] act, exp_b;

  assign act   = {o_de, o_hs, o_vs, o_cx, o_cy, o_x, o_y, o_cnt};
  assign exp_b = {e_de, e_hs, e_vs, e_cx, e_cy, 16'h0, 16'h0, 8'h0};

  task automatic model_reset();
    pos = 0; sh_cx = '0; sh_cy = '0; sh_st = '0;
    e_de = 0; e_hs = 0; e_vs = 0; e_cx = '0; e_cy = '0;
  endtask

  task automatic model_tick();
    int h, v;
    if (!i_rst && i_ce) begin
      h = pos % HT;
      v = pos / HT;
      if (pos == 0) begin sh_cx = i_cx0; sh_cy = i_cy0; sh_st = i_step; end
      e_de = (h < HA) && (v < VA);
      e_hs = (h >= HA + HF) && (h < HA + HF + HS);
      e_vs = (v >= VA + VF) && (v < VA + VF + VS);
      e_cx = e_de ? 16'(32'(sh_cx) + h * 32'(sh_st)) : 16'h0;
      e_cy = e_de ? 16'(32'(sh_cy) - v * 32'(sh_st)) : 16'h0;
      pos  = (pos + 1) % FT;
    end
  endtask

  task automatic cyc(input logic ce);
    i_ce = ce;
    model_tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    model_reset();
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
  endtask

  task automatic test_reset();
    i_ce = 1'b1; i_cx0 = 16'h1000; i_cy0 = 16'h0200; i_step = 16'h0010;
    i_rst = 1'b1;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      @(posedge i_clk); #1;
      checks++;
      if (act !== 75'h0) begin
        failures++; $display("FAIL reset_hold: got %h want 0", act);
      end
    end
    i_rst = 1'b0;
    cyc(1'b1);
    checks++;
    if (o_de !== 1'b1 || o_cx !== 16'h1000) begin
      failures++; $display("FAIL reset_first: de=%b cx=%h want de=1 cx=1000", o_de, o_cx);
    end
  endtask

  task automatic test_sweep();
    logic [15:0] cxtab [4];
    logic [15:0] cytab [3];
    int n_de, n_hs, n_vs;
    cxtab = '{16'hE000, 16'hE100, 16'hE200, 16'hE300};
    cytab = '{16'h1000, 16'h0F00, 16'h0E00};
    i_cx0 = 16'hE000; i_cy0 = 16'h1000; i_step = 16'h0100;
    do_reset();
    n_de = 0; n_hs = 0; n_vs = 0;
    for (int k = 0; k < FT; k++) begin
      cyc(1'b1);
      checks++;
      if (act !== exp_b) begin
        failures++; $display("FAIL sweep_model k=%0d: got %h want %h", k, act, exp_b);
      end
      if ((k % HT) < HA && (k / HT) < VA) begin
        checks++;
        if (o_cx !== cxtab[k % HT] || o_cy !== cytab[k / HT]) begin
          failures++;
          $display("FAIL sweep_coord k=%0d: cx=%h cy=%h want %h %h", k, o_cx, o_cy,
                   cxtab[k % HT], cytab[k / HT]);
        end
      end
      n_de += int'(o_de); n_hs += int'(o_hs); n_vs += int'(o_vs);
      if (o_hs) begin
        checks++;
        if ((k % HT) != 5 && (k % HT) != 6) begin
          failures++; $display("FAIL hs_pos: hs=1 at h=%0d want h in 5..6", k % HT);
        end
      end
    end
    checks++;
    if (n_de != 12 || n_hs != 12 || n_vs != 8) begin
      failures++; $display("FAIL frame_shape: de=%0d hs=%0d vs=%0d want 12 12 8", n_de, n_hs, n_vs);
    end
    cyc(1'b1);
    checks++;
    if (o_de !== 1'b1 || o_cx !== 16'hE000 || o_cy !== 16'h1000) begin
      failures++; $display("FAIL frame_period: de=%b cx=%h cy=%h want 1 E000 1000", o_de, o_cx, o_cy);
    end
  endtask

  task automatic test_midframe();
    i_cx0 = 16'hE000; i_cy0 = 16'h1000; i_step = 16'h0100;
    do_reset();
    for (int k = 0; k < FT; k++) begin
      if (k == HT) i_cx0 = 16'h0000;
      cyc(1'b1);
      checks++;
      if (act !== exp_b) begin
        failures++; $display("FAIL midframe_model k=%0d: got %h want %h", k, act, exp_b);
      end
      if (k == HT + 1) begin
        checks++;
        if (o_cx !== 16'hE100) begin
          failures++; $display("FAIL midframe_hold: cx=%h want E100", o_cx);
        end
      end
    end
    cyc(1'b1);
    checks++;
    if (o_de !== 1'b1 || o_cx !== 16'h0000) begin
      failures++; $display("FAIL midframe_next: de=%b cx=%h want 1 0000", o_de, o_cx);
    end
  endtask

  task automatic test_ce_gating();
    logic [74:0] ref_seq [FT];
    logic [74:0] prev;
    int idx;
    i_cx0 = 16'h1234; i_cy0 = 16'hF000; i_step = 16'h0333;
    do_reset();
    for (int k = 0; k < FT; k++) begin cyc(1'b1); ref_seq[k] = act; end
    do_reset();
    idx = 0;
    prev = act;
    for (int k = 0; k < 2 * FT; k++) begin
      cyc((k % 2) == 0);
      checks++;
      if (i_ce) begin
        if (act !== ref_seq[idx] || act !== exp_b) begin
          failures++; $display("FAIL ce_seq idx=%0d: got %h want %h", idx, act, ref_seq[idx]);
        end
        idx++;
      end else if (act !== prev) begin
        failures++; $display("FAIL ce_hold k=%0d: got %h want %h", k, act, prev);
      end
      prev = act;
    end
  endtask

  task automatic test_wrap();
    logic [15:0] wtab [4];
    wtab = '{16'h7F80, 16'h7FC0, 16'h8000, 16'h8040};
    i_cx0 = 16'h7F80; i_cy0 = 16'h8020; i_step = 16'h0040;
    do_reset();
    for (int k = 0; k < 2 * HT; k++) begin
      cyc(1'b1);
      checks++;
      if (act !== exp_b) begin
        failures++; $display("FAIL wrap_model k=%0d: got %h want %h", k, act, exp_b);
      end
      if ((k % HT) < HA) begin
        checks++;
        if (o_cx !== wtab[k % HT]) begin
          failures++; $display("FAIL wrap_cx k=%0d: got %h want %h", k, o_cx, wtab[k % HT]);
        end
      end
    end
    checks++;
    if (o_cy !== 16'h0 || e_cy !== 16'h0) begin
      failures++; $display("FAIL wrap_blank_cy: got %h want 0", o_cy);
    end
  endtask

  task automatic test_midreset();
    i_cx0 = 16'h1000; i_cy0 = 16'h0800; i_step = 16'h0010;
    do_reset();
    for (int k = 0; k < HT + 2; k++) cyc(1'b1);
    checks++;
    if (o_de !== 1'b1 || o_cx !== 16'h1010 || o_cy !== 16'h07F0) begin
      failures++; $display("FAIL premid: de=%b cx=%h cy=%h want 1 1010 07F0", o_de, o_cx, o_cy);
    end
    #1 i_rst = 1'b1;
    #1;
    checks++;
    if (act !== 75'h0) begin
      failures++; $display("FAIL midreset_async: got %h want 0", act);
    end
    i_rst = 1'b0;
    model_reset();
    for (int k = 0; k < 2 * HT; k++) begin
      cyc(1'b1);
      checks++;
      if (act !== exp_b) begin
        failures++; $display("FAIL midreset_restart k=%0d: got %h want %h", k, act, exp_b);
      end
    end
  endtask

  task automatic test_random();
    i_cx0 = 16'($urandom); i_cy0 = 16'($urandom); i_step = 16'($urandom);
    do_reset();
    for (int k = 0; k < 6 * FT; k++) begin
      if ($urandom_range(0, 9) == 0) i_cx0 = 16'($urandom);
      if ($urandom_range(0, 9) == 0) i_cy0 = 16'($urandom);
      if ($urandom_range(0, 9) == 0) i_step = 16'($urandom);
      cyc($urandom_range(0, 3) != 0);
      checks++;
      if (act !== exp_b) begin
        failures++; $display("FAIL random k=%0d: got %h want %h", k, act, exp_b);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_sweep();
    test_midframe();
    test_ce_gating();
    test_wrap();
    test_midreset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mandel_pixel_gen.md
# mandel_pixel_gen

Head of the Mandelbrot pixel pipeline. Generates video timing (data enable, horizontal sync, vertical sync) and, for every active pixel, the complex-plane coordinate c in Q4.12. It drives the first iteration stage with z = 0 and count = 0. Its outputs connect one-to-one to the iteration stage's inputs, so a chain of iteration stages hangs directly off this block.

## Interface
Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)

Ports:
- i_clk  in  1  clock; one clock only
- i_rst  in  1  reset; asynchronous, active-high
- i_ce  in  1  pixel clock enable; the block's state advances only when i_ce=1
- i_cx0  in  16 signed  real part of the top-left pixel, Q4.12
- i_cy0  in  16 signed  imaginary part of the top-left pixel, Q4.12
- i_step  in  16 signed  per-pixel and per-line coordinate step, Q4.12
- o_de  out  1  active-pixel flag
- o_hs  out  1  horizontal sync; active-high during the sync pulse
- o_vs  out  1  vertical sync; active-high during the sync lines
- o_x, o_y  out  16 signed  initial z; constant 0
- o_cx, o_cy  out  16 signed  pixel coordinate c, Q4.12
- o_cnt  out  8  initial iteration count; constant 0

## Operation
- Internal counters:
  - h counts 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP.
  - v counts 0..V_TOTAL-1, where V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
  - Each i_ce cycle, h increments. When h wraps to 0, v increments. When v wraps past V_TOTAL-1, it returns to 0.
- Decodes for position (h,v):
  - de = h<H_ACTIVE && v<V_ACTIVE
  - hs = H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC
  - vs = V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, asserted for all h of those lines
- Frame parameter capture:
  - On the i_ce cycle where (h,v)=(0,0), i_cx0, i_cy0 and i_step are captured into shadow registers.
  - That pixel uses the live inputs directly.
  - Input changes at any other time have no effect until the next frame start.
- Coordinate accumulators (no multiplier):
  - cx_acc loads cx0 at h=0 of each line, then adds step after each active pixel.
  - cy_acc loads cy0 at frame start, then subtracts step at the end of each active line, so rows run downward.
  - The result is c = (cx0 + h·step, cy0 − v·step) for active pixels.
- Arithmetic: 16-bit two's complement, wrap-around on overflow, no saturation.
- Output rules:
  - o_cx/o_cy carry c while o_de=1, and are forced to 0 while o_de=0.
  - o_x, o_y and o_cnt are always 0.
- Reset (asynchronous, active-high): h, v, accumulators, shadow registers and all outputs clear to 0 immediately. The first i_ce cycle after release is position (0,0).

## Timing
- All outputs are registered.
- The outputs for position (h,v) appear after the clock edge of the i_ce cycle at which the counters hold (h,v). Latency is one clock.
- i_ce=0: every register holds, including the outputs. The output sequence is identical to the i_ce=1 sequence, only stretched.
- One line is H_TOTAL i_ce cycles; one frame is H_TOTAL·V_TOTAL i_ce cycles.
- Simultaneous events:
  - At the last pixel of the last line, the h and v wraps and the parameter capture all happen in the same cycle.
  - Reset asserted mid-frame overrides everything asynchronously. No partial frame resumes after reset.
- Reset value of every output: 0. This includes o_de, o_hs, o_vs, o_cx and o_cy.

## Structure
- Shared package mandel_pkg holds:
  - FRAC_BITS=12 and the Q4.12 word width 16
  - the escape threshold 16'sh4000 (4.0)
  - the default 640x480 timing constants
- Sub-module video_timing (counters h/v plus de/hs/vs decode, i_ce-gated) is natural. mandel_pixel_gen adds parameter capture, the accumulators and output registration.

## Test plan
Small parameters: H=4/1/2/1 (H_TOTAL 8), V=3/1/1/1 (V_TOTAL 6).
- Reset: assert i_rst with i_ce=1, cx0=0x1000 → all outputs 0 while in reset. After release, the first edge gives o_de=1 and o_cx=0x1000.
- Coordinate sweep: cx0=0xE000, cy0=0x1000, step=0x0100 → each line gives o_cx=E000, E100, E200, E300. o_cy=1000 on line 0, 0F00 on line 1, 0E00 on line 2. o_cx/o_cy=0 whenever o_de=0.
- Sync and frame shape:
  - o_hs=1 for h=5,6 of every line.
  - o_vs=1 for all 8 cycles of v=4.
  - 12 o_de cycles per frame, and the frame period is 48 cycles.
- Mid-frame change: change cx0 to 0x0000 at v=1 → the current frame still uses 0xE000. The next frame's first pixel gives o_cx=0x0000.
- i_ce gating: drive i_ce alternating 1,0 → outputs hold on i_ce=0 cycles, and the sampled sequence matches the i_ce=1 run exactly.
- Wrap and mid-frame reset:
  - cx0=0x7F80, step=0x0040 → o_cx=7F80, 7FC0, 8000, 8040.
  - Pulse i_rst at h=2,v=1 → outputs go to 0 at once, and the block restarts at (0,0) after release.
